// File: rtl/bp_fe_pkg.sv
// Shared front-end icache types: refill FSM states, the line width, and a macro
// that declares the {addr, instr} response struct for a given address/instr width.
`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV

`define BP_FE_DECLARE_ICACHE_PC_GEN_S(eaddr_width_mp, instr_width_mp) \
    typedef struct packed { \
        logic [eaddr_width_mp-1:0] addr; \
        logic [instr_width_mp-1:0] instr; \
    } bp_fe_icache_pc_gen_s

package bp_fe_pkg;

    localparam int line_width_gp = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } bp_fe_icache_state_e;

endpackage

`endif

// File: rtl/bp_fe_icache_responder_if.sv
// Fetch request/response, refill memory and flush signals of the icache responder.
// The slave modport is the cache side; master is the requester/memory side.
interface bp_fe_icache_responder_if #(
    parameter int eaddr_width_p = 64,
    parameter int instr_width_p = 32
);
    import bp_fe_pkg::*;

    logic [eaddr_width_p-1:0]               pc_gen_icache_i;
    logic                                   pc_gen_icache_v_i;
    logic                                   pc_gen_icache_ready_o;
    logic [eaddr_width_p+instr_width_p-1:0] icache_pc_gen_o;
    logic                                   icache_pc_gen_v_o;
    logic                                   icache_miss_o;
    logic [eaddr_width_p-1:0]               mem_req_addr_o;
    logic                                   mem_req_v_o;
    logic                                   mem_req_ready_i;
    logic [line_width_gp-1:0]               mem_resp_data_i;
    logic                                   mem_resp_v_i;
    logic                                   flush_i;

    modport slave (
        input  pc_gen_icache_i, pc_gen_icache_v_i, mem_req_ready_i,
        input  mem_resp_data_i, mem_resp_v_i, flush_i,
        output pc_gen_icache_ready_o, icache_pc_gen_o, icache_pc_gen_v_o,
        output icache_miss_o, mem_req_addr_o, mem_req_v_o
    );

    modport master (
        output pc_gen_icache_i, pc_gen_icache_v_i, mem_req_ready_i,
        output mem_resp_data_i, mem_resp_v_i, flush_i,
        input  pc_gen_icache_ready_o, icache_pc_gen_o, icache_pc_gen_v_o,
        input  icache_miss_o, mem_req_addr_o, mem_req_v_o
    );

endinterface

// File: rtl/bp_fe_icache_tag_array.sv
// Direct-mapped tag/valid/data storage: combinational read, synchronous write,
// flush clears every valid bit at the next edge.
module bp_fe_icache_tag_array
    import bp_fe_pkg::*;
#(
    parameter int sets_p      = 16,
    parameter int tag_width_p = 56,
    localparam int index_width_lp = $clog2(sets_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      i_flush,
    input  logic                      i_w_v,
    input  logic [index_width_lp-1:0] i_w_index,
    input  logic [tag_width_p-1:0]    i_w_tag,
    input  logic [line_width_gp-1:0]  i_w_data,
    input  logic [index_width_lp-1:0] i_r_index,
    output logic                      o_r_valid,
    output logic [tag_width_p-1:0]    o_r_tag,
    output logic [line_width_gp-1:0]  o_r_data
);

    logic [sets_p-1:0]        r_valid;
    logic [sets_p-1:0]        w_valid_next;
    logic [tag_width_p-1:0]   r_tag  [sets_p];
    logic [line_width_gp-1:0] r_data [sets_p];

    // Next valid vector: a fill landing together with a flush keeps its own line
    always_comb begin
        w_valid_next = '0;
        for (int i = 0; i < sets_p; i++) begin
            w_valid_next[i] = (r_valid[i] & ~i_flush)
                            | (i_w_v & (i_w_index == index_width_lp'(i)));
        end
    end

    // Valid bits are the only reset state in the array
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_next;
        end
    end

    // Tag and data storage
    always_ff @(posedge clk_i) begin
        if (i_w_v) begin
            r_tag[i_w_index]  <= i_w_tag;
            r_data[i_w_index] <= i_w_data;
        end
    end

    assign o_r_valid = r_valid[i_r_index];
    assign o_r_tag   = r_tag[i_r_index];
    assign o_r_data  = r_data[i_r_index];

endmodule

// File: rtl/bp_fe_icache_responder.sv
// Direct-mapped front-end icache responder with a blocking single-line refill.
// Define BP_FE_ICACHE_RESPONDER_PERF_EN to add saturating hit/miss counters.
module bp_fe_icache_responder
    import bp_fe_pkg::*;
#(
    parameter int eaddr_width_p = 64,
    parameter int instr_width_p = 32,
    parameter int sets_p        = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
`ifdef BP_FE_ICACHE_RESPONDER_PERF_EN
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o,
`endif
    bp_fe_icache_responder_if.slave bus_if
);

    localparam int line_width_lp  = line_width_gp;
    localparam int index_width_lp = $clog2(sets_p);
    localparam int tag_width_lp   = eaddr_width_p - 4 - index_width_lp;

    `BP_FE_DECLARE_ICACHE_PC_GEN_S(eaddr_width_p, instr_width_p);

    bp_fe_icache_state_e      r_state;
    logic                     r_miss;
    logic                     r_resp_v;
    bp_fe_icache_pc_gen_s     r_resp;
    logic                     r_mem_req_v;
    logic [eaddr_width_p-1:0] r_mem_req_addr;
    logic [line_width_lp-1:0] r_fill_data;

    logic [1:0]                w_word;
    logic [index_width_lp-1:0] w_index;
    logic [tag_width_lp-1:0]   w_tag;
    logic                      w_ready;
    logic                      w_fire;
    logic                      w_hit;
    logic                      w_fill;
    logic                      w_arr_valid;
    logic [tag_width_lp-1:0]   w_arr_tag;
    logic [line_width_lp-1:0]  w_arr_data;
    logic [instr_width_p-1:0]  w_instr;
    logic                      w_unused_byte_offset;

    assign w_word   = bus_if.pc_gen_icache_i[3:2];
    assign w_index  = bus_if.pc_gen_icache_i[4 +: index_width_lp];
    assign w_tag    = bus_if.pc_gen_icache_i[eaddr_width_p-1 -: tag_width_lp];
    assign w_unused_byte_offset = ^bus_if.pc_gen_icache_i[1:0];

    // Gating with reset keeps ready low while the block is held in reset
    assign w_ready = reset_n_i & (r_state == IDLE) & ~r_miss;
    assign w_fire  = w_ready & bus_if.pc_gen_icache_v_i;
    assign w_hit   = w_arr_valid & (w_arr_tag == w_tag) & ~bus_if.flush_i;
    assign w_instr = w_arr_data[w_word*instr_width_p +: instr_width_p];
    assign w_fill  = (r_state == FILL);

    bp_fe_icache_tag_array #(
        .sets_p      (sets_p),
        .tag_width_p (tag_width_lp)
    ) tag_array (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .i_flush   (bus_if.flush_i),
        .i_w_v     (w_fill),
        .i_w_index (r_mem_req_addr[4 +: index_width_lp]),
        .i_w_tag   (r_mem_req_addr[eaddr_width_p-1 -: tag_width_lp]),
        .i_w_data  (r_fill_data),
        .i_r_index (w_index),
        .o_r_valid (w_arr_valid),
        .o_r_tag   (w_arr_tag),
        .o_r_data  (w_arr_data)
    );

    // Lookup response and refill FSM with all of its registered outputs
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state        <= IDLE;
            r_miss         <= 1'b0;
            r_resp_v       <= 1'b0;
            r_resp         <= '0;
            r_mem_req_v    <= 1'b0;
            r_mem_req_addr <= '0;
            r_fill_data    <= '0;
        end else begin
            r_resp_v <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        if (w_hit) begin
                            r_resp_v     <= 1'b1;
                            r_resp.addr  <= bus_if.pc_gen_icache_i;
                            r_resp.instr <= w_instr;
                        end else begin
                            r_state        <= REQ;
                            r_miss         <= 1'b1;
                            r_mem_req_v    <= 1'b1;
                            r_mem_req_addr <= {bus_if.pc_gen_icache_i[eaddr_width_p-1:4], 4'b0000};
                        end
                    end
                end
                REQ: begin
                    if (bus_if.mem_req_ready_i) begin
                        r_mem_req_v <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus_if.mem_resp_v_i) begin
                        r_fill_data <= bus_if.mem_resp_data_i;
                        r_state     <= FILL;
                    end
                end
                FILL: begin
                    r_miss  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_miss      <= 1'b0;
                    r_mem_req_v <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus_if.pc_gen_icache_ready_o = w_ready;
    assign bus_if.icache_pc_gen_o       = r_resp;
    assign bus_if.icache_pc_gen_v_o     = r_resp_v;
    assign bus_if.icache_miss_o         = r_miss;
    assign bus_if.mem_req_addr_o        = r_mem_req_addr;
    assign bus_if.mem_req_v_o           = r_mem_req_v;

`ifdef BP_FE_ICACHE_RESPONDER_PERF_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Saturating counters of accepted hits and misses
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if (w_fire & w_hit & (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_fire & ~w_hit & (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count_o  = r_hit_count;
    assign miss_count_o = r_miss_count;
`endif

endmodule

// File: tb/tb_bp_fe_icache_responder.sv
// Bench for bp_fe_icache_responder: directed refill/flush/reset scenarios and a
// randomized phase, all checked per cycle against a line-level cache model.
module tb_bp_fe_icache_responder;

    localparam int EW   = 64;
    localparam int IW   = 32;
    localparam int SETS = 16;

    localparam logic [127:0] LINE_A = {32'h00FFEEDD, 32'hCCBBAA99, 32'h88776655, 32'h44332211};
    localparam logic [127:0] LINE_B = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
    localparam logic [127:0] LINE_C = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
    localparam logic [127:0] LINE_D = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};

    logic clk_i     = 1'b0;
    logic reset_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    bp_fe_icache_responder_if #(.eaddr_width_p(EW), .instr_width_p(IW)) bus_if ();

`ifdef BP_FE_ICACHE_RESPONDER_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    bp_fe_icache_responder #(.eaddr_width_p(EW), .instr_width_p(IW), .sets_p(SETS)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
`ifdef BP_FE_ICACHE_RESPONDER_PERF_EN
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count),
`endif
        .bus_if    (bus_if)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of the cache: per-set contents plus where the single refill stands
    logic         m_valid [SETS];
    logic [55:0]  m_tag   [SETS];
    logic [127:0] m_line  [SETS];
    int           m_step = 0;   // 0 free, 1 request out, 2 awaiting data, 3 line being written
    logic [127:0] m_fill_data;
    logic         e_v = 1'b0, e_miss = 1'b0, e_mreq_v = 1'b0;
    logic [63:0]  e_addr = '0, e_maddr = '0;
    logic [31:0]  e_instr = '0;
    int unsigned  m_hits = 0, m_misses = 0;

    always @(posedge clk_i) begin : model
        int idx;
        int word;
        logic hit;
        logic do_fill;
        do_fill = 1'b0;
        if (!reset_n_i) begin
            for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
            m_step = 0; e_v = 1'b0; e_miss = 1'b0; e_mreq_v = 1'b0;
            e_addr = '0; e_maddr = '0; e_instr = '0; m_hits = 0; m_misses = 0;
        end else begin
            e_v = 1'b0;
            if (m_step == 0 && bus_if.pc_gen_icache_v_i) begin
                idx  = int'((bus_if.pc_gen_icache_i >> 4) % SETS);
                word = int'((bus_if.pc_gen_icache_i >> 2) % 4);
                hit  = m_valid[idx] && (m_tag[idx] == 56'(bus_if.pc_gen_icache_i >> 8)) && !bus_if.flush_i;
                if (hit) begin
                    e_v = 1'b1;
                    e_addr = bus_if.pc_gen_icache_i;
                    e_instr = 32'(m_line[idx] >> (32 * word));
                    m_hits++;
                end else begin
                    m_step = 1; e_miss = 1'b1; e_mreq_v = 1'b1;
                    e_maddr = bus_if.pc_gen_icache_i & ~64'hF;
                    m_misses++;
                end
            end else if (m_step == 1 && bus_if.mem_req_ready_i) begin
                e_mreq_v = 1'b0; m_step = 2;
            end else if (m_step == 2 && bus_if.mem_resp_v_i) begin
                m_fill_data = bus_if.mem_resp_data_i; m_step = 3;
            end else if (m_step == 3) begin
                do_fill = 1'b1;
            end
            if (bus_if.flush_i) for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
            if (do_fill) begin
                idx = int'((e_maddr >> 4) % SETS);
                m_valid[idx] = 1'b1;
                m_tag[idx]   = 56'(e_maddr >> 8);
                m_line[idx]  = m_fill_data;
                m_step = 0; e_miss = 1'b0;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    always begin
        @(posedge clk_i);
        #1;
        check("ready", bus_if.pc_gen_icache_ready_o, reset_n_i && (m_step == 0));
        check("resp_v", bus_if.icache_pc_gen_v_o, e_v);
        check("miss", bus_if.icache_miss_o, e_miss);
        check("mem_req_v", bus_if.mem_req_v_o, e_mreq_v);
        if (e_v) check("resp", bus_if.icache_pc_gen_o, {e_addr, e_instr});
        if (e_mreq_v) check("mem_req_addr", bus_if.mem_req_addr_o, e_maddr);
    end

    task automatic send(input logic [63:0] a);
        bus_if.pc_gen_icache_i   = a;
        bus_if.pc_gen_icache_v_i = 1'b1;
        @(negedge clk_i);
        bus_if.pc_gen_icache_v_i = 1'b0;
    endtask

    // Waits for the refill to be waiting on data, returns the line, checks the miss edge
    task automatic serve(input logic [127:0] d);
        int n = 0;
        while (!(bus_if.icache_miss_o && !bus_if.mem_req_v_o) && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        check("serve_wait_bound", n < 40, 1'b1);
        bus_if.mem_resp_data_i = d;
        bus_if.mem_resp_v_i    = 1'b1;
        @(negedge clk_i);
        bus_if.mem_resp_v_i    = 1'b0;
        check("fill_miss_high", bus_if.icache_miss_o, 1'b1);
        @(negedge clk_i);
        check("miss_fell", bus_if.icache_miss_o, 1'b0);
        check("ready_after_fill", bus_if.pc_gen_icache_ready_o, 1'b1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] lo;
        bus_if.pc_gen_icache_i   = '0;
        bus_if.pc_gen_icache_v_i = 1'b0;
        bus_if.mem_req_ready_i   = 1'b1;
        bus_if.mem_resp_data_i   = '0;
        bus_if.mem_resp_v_i      = 1'b0;
        bus_if.flush_i           = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_resp_v", bus_if.icache_pc_gen_v_o, 1'b0);
        check("rst_miss", bus_if.icache_miss_o, 1'b0);
        check("rst_mem_req_v", bus_if.mem_req_v_o, 1'b0);
        check("rst_ready", bus_if.pc_gen_icache_ready_o, 1'b0);
        check("rst_resp", bus_if.icache_pc_gen_o, 96'h0);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        check("ready_after_rst", bus_if.pc_gen_icache_ready_o, 1'b1);

        // First miss, refill, replay
        send(64'h8000_0000);
        check("s1_miss", bus_if.icache_miss_o, 1'b1);
        check("s1_no_resp", bus_if.icache_pc_gen_v_o, 1'b0);
        check("s1_mem_req_v", bus_if.mem_req_v_o, 1'b1);
        check("s1_mem_addr", bus_if.mem_req_addr_o, 64'h8000_0000);
        serve(LINE_A);
        send(64'h8000_0000);
        check("s1_replay_v", bus_if.icache_pc_gen_v_o, 1'b1);
        check("s1_replay", bus_if.icache_pc_gen_o, {64'h8000_0000, 32'h44332211});

        // Streaming hits on words 1..3
        bus_if.pc_gen_icache_v_i = 1'b1;
        bus_if.pc_gen_icache_i = 64'h8000_0004;
        @(negedge clk_i);
        check("s2_w1", bus_if.icache_pc_gen_o, {64'h8000_0004, 32'h88776655});
        bus_if.pc_gen_icache_i = 64'h8000_0008;
        @(negedge clk_i);
        check("s2_w2", bus_if.icache_pc_gen_o, {64'h8000_0008, 32'hCCBBAA99});
        bus_if.pc_gen_icache_i = 64'h8000_000C;
        @(negedge clk_i);
        check("s2_w3", bus_if.icache_pc_gen_o, {64'h8000_000C, 32'h00FFEEDD});
        check("s2_v3", bus_if.icache_pc_gen_v_o, 1'b1);
        bus_if.pc_gen_icache_v_i = 1'b0;
        @(negedge clk_i);
        check("s2_v_drop", bus_if.icache_pc_gen_v_o, 1'b0);

        // Conflict on index 0
        send(64'h8000_0100);
        check("s3_miss", bus_if.icache_miss_o, 1'b1);
        check("s3_mem_addr", bus_if.mem_req_addr_o, 64'h8000_0100);
        serve(LINE_B);
        send(64'h8000_0100);
        check("s3_hit", bus_if.icache_pc_gen_o, {64'h8000_0100, 32'hB0B0B0B0});
        send(64'h8000_0000);
        check("s3_evicted", bus_if.icache_miss_o, 1'b1);
        check("s3_evicted_v", bus_if.icache_pc_gen_v_o, 1'b0);
        serve(LINE_A);

        // Memory stalls the request for five cycles
        bus_if.mem_req_ready_i = 1'b0;
        send(64'h8000_0020);
        for (int i = 0; i < 5; i++) begin
            check("s4_req_v", bus_if.mem_req_v_o, 1'b1);
            check("s4_req_addr", bus_if.mem_req_addr_o, 64'h8000_0020);
            check("s4_ready", bus_if.pc_gen_icache_ready_o, 1'b0);
            @(negedge clk_i);
        end
        bus_if.mem_req_ready_i = 1'b1;
        serve(LINE_D);
        send(64'h8000_0028);
        check("s4_hit", bus_if.icache_pc_gen_o, {64'h8000_0028, 32'hD2D2D2D2});

        // Flush during WAIT
        send(64'h8000_0040);
        @(negedge clk_i);
        bus_if.flush_i = 1'b1;
        @(negedge clk_i);
        bus_if.flush_i = 1'b0;
        serve(LINE_C);
        send(64'h8000_0040);
        check("s5_hit", bus_if.icache_pc_gen_o, {64'h8000_0040, 32'hC0C0C0C0});
        check("s5_hit_v", bus_if.icache_pc_gen_v_o, 1'b1);
        send(64'h8000_0000);
        check("s5_other_miss0", bus_if.icache_miss_o, 1'b1);
        serve(LINE_A);
        send(64'h8000_0020);
        check("s5_other_miss2", bus_if.icache_miss_o, 1'b1);
        serve(LINE_D);

        // Reset during WAIT, then a stale response
        send(64'h8000_0060);
        @(negedge clk_i);
        reset_n_i = 1'b0;
        @(negedge clk_i);
        check("s6_rst_miss", bus_if.icache_miss_o, 1'b0);
        check("s6_rst_mem_addr", bus_if.mem_req_addr_o, 64'h0);
        check("s6_rst_ready", bus_if.pc_gen_icache_ready_o, 1'b0);
        reset_n_i = 1'b1;
        bus_if.mem_resp_data_i = LINE_B;
        bus_if.mem_resp_v_i = 1'b1;
        @(negedge clk_i);
        bus_if.mem_resp_v_i = 1'b0;
        check("s6_stale_ignored", bus_if.icache_miss_o, 1'b0);
        check("s6_idle_ready", bus_if.pc_gen_icache_ready_o, 1'b1);
        send(64'h8000_0060);
        check("s6_next_miss", bus_if.icache_miss_o, 1'b1);
        serve(LINE_D);
        send(64'h8000_0000);
        check("s6_cleared_miss", bus_if.icache_miss_o, 1'b1);
        serve(LINE_A);

        // Randomized traffic; model and checker keep running
        for (int c = 0; c < 3000; c++) begin
            lo = 32'h8000_0000 | (32'($urandom_range(0, 2)) << 8)
               | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
            bus_if.pc_gen_icache_i   = {32'h0, lo};
            bus_if.pc_gen_icache_v_i = ($urandom % 4) != 0;
            bus_if.flush_i           = ($urandom % 40) == 0;
            bus_if.mem_req_ready_i   = ($urandom % 2) == 0;
            bus_if.mem_resp_v_i      = ($urandom % 3) == 0;
            bus_if.mem_resp_data_i   = {$urandom, $urandom, $urandom, $urandom};
            reset_n_i                = ($urandom % 700) != 0;
            @(negedge clk_i);
        end
        bus_if.pc_gen_icache_v_i = 1'b0;
        bus_if.flush_i           = 1'b0;
        bus_if.mem_resp_v_i      = 1'b0;
        reset_n_i                = 1'b1;
        repeat (3) @(negedge clk_i);
`ifdef BP_FE_ICACHE_RESPONDER_PERF_EN
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bp_fe_icache_responder.md
BP_FE_ICACHE_RESPONDER -- requirements
Module: bp_fe_icache_responder

Interface
REQ-001 SHALL have parameter eaddr_width_p, default 64, meaning effective fetch address width.
REQ-002 SHALL have parameter instr_width_p, default 32, meaning instruction width.
REQ-003 SHALL have parameter sets_p, default 16, meaning number of direct-mapped lines; power of 2, at least 2.
REQ-004 SHALL have localparam line_width_lp = 128, meaning 4 instructions per line.
REQ-005 SHALL have port clk_i  input  1  the single clock.
REQ-006 SHALL have port reset_n_i  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port pc_gen_icache_i  input  eaddr_width_p  fetch virtual address.
REQ-008 SHALL have port pc_gen_icache_v_i  input  1  fetch request valid.
REQ-009 SHALL have port pc_gen_icache_ready_o  output  1  fetch request accepted when high together with v.
REQ-010 SHALL have port icache_pc_gen_o  output  eaddr_width_p+instr_width_p  {addr, instr} response.
REQ-011 SHALL have port icache_pc_gen_v_o  output  1  response valid.
REQ-012 SHALL have port icache_miss_o  output  1  miss in progress; the requester replays on the falling edge of this signal.
REQ-013 SHALL have port mem_req_addr_o  output  eaddr_width_p  line-aligned refill address.
REQ-014 SHALL have port mem_req_v_o / mem_req_ready_i  output/input  1  refill request handshake.
REQ-015 SHALL have port mem_resp_data_i  input  line_width_lp  refill line, with instr0 in bits [31:0].
REQ-016 SHALL have port mem_resp_v_i  input  1  refill data valid.
REQ-017 SHALL have port flush_i  input  1  invalidate all lines.

Function
REQ-018 Address split SHALL be: word = addr[3:2]; index = addr[4 +: log2(sets_p)]; tag = remaining upper bits; addr[1:0] ignored.
REQ-019 pc_gen_icache_ready_o SHALL equal (state==IDLE) & ~miss_pending.
REQ-020 A hit accepted in cycle N SHALL produce icache_pc_gen_v_o=1 in N+1, with the registered addr and the selected word, for exactly one cycle; back-to-back hits SHALL stream at 1 per cycle.
REQ-021 A miss accepted in cycle N SHALL give icache_pc_gen_v_o=0 in N+1 and set icache_miss_o=1 from N+1.
REQ-022 FSM states SHALL be IDLE -> REQ -> WAIT -> FILL -> IDLE. REQ drives mem_req_v_o until mem_req_ready_i. WAIT lasts until mem_resp_v_i. FILL writes data, tag and valid in one cycle.
REQ-023 icache_miss_o SHALL stay high through the FILL cycle and be low in the following IDLE cycle. No response is issued for the missed address; the requester re-sends it.
REQ-024 mem_req_addr_o SHALL be {tag, index, 4'b0} of the missed address and be held stable while mem_req_v_o is high.
REQ-025 flush_i SHALL clear all valid bits at the next edge. A request in the same cycle SHALL be treated as a miss. A flush during REQ or WAIT SHALL NOT abort the refill, and FILL SHALL still set the valid bit.
REQ-026 mem_resp_v_i outside WAIT SHALL be ignored.

Reset
REQ-027 On reset_n_i low, all outputs SHALL be 0, state SHALL be IDLE, and all valid bits SHALL be 0, asynchronously. Data and tag arrays need no reset.
REQ-028 Reset asserted mid-refill SHALL abandon the refill. A later stale mem_resp_v_i SHALL be ignored per REQ-026.

Configuration
REQ-029 With BP_FE_ICACHE_RESPONDER_PERF_EN defined, outputs hit_count_o[31:0] and miss_count_o[31:0] SHALL exist. They SHALL count accepted hits and misses, saturate at all-ones, and reset to 0.
REQ-030 Without the macro, neither these ports nor the counters SHALL exist, and behaviour SHALL otherwise be identical.

Structure
REQ-031 bp_fe_pkg SHALL hold the FSM state enum, the line-width constant, and a macro declaring the icache_pc_gen {addr, instr} struct.
REQ-032 Tag, valid and data storage SHALL be one sub-module, bp_fe_icache_tag_array: combinational read, synchronous write, one-cycle flush.

Verification
REQ-033 Bench SHALL cover (sets_p=16): after reset, request 0x80000000 -> miss_o=1 at N+1, mem_req_addr_o=0x80000000. Response line 0x...44332211 -> FILL, miss_o falls. Replay -> v_o=1, instr=0x44332211.
REQ-034 Bench SHALL cover: after filling line 0x80000000, requests 0x80000004, 0x80000008 and 0x8000000C on consecutive cycles -> three consecutive v_o cycles returning words 1, 2 and 3.
REQ-035 Bench SHALL cover: line 0x80000000 filled, then request 0x80000100 (same index, different tag) -> miss, refill replaces the line, and 0x80000000 then misses again.
REQ-036 Bench SHALL cover: mem_req_ready_i held low 5 cycles -> mem_req_v_o and the address held stable, ready_o=0 throughout.
REQ-037 Bench SHALL cover: flush_i pulsed during WAIT -> refill completes, that line hits, and all other previously valid lines miss.
REQ-038 Bench SHALL cover: reset_n_i low during WAIT, then mem_resp_v_i -> state IDLE, no array write, next request misses.
